// File: rtl/axis_s2mm_burst_writer.sv
// S2MM write engine: pops stream FIFO words and issues them as AXI4 INCR write
// bursts, one burst in flight, clipped to MAX_BURST, remaining length and 4 KB.
module axis_s2mm_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    total_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    fifo_not_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int CW    = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, calc_addr, awaddr_q;
  logic [LEN_WIDTH-1:0]  remaining, calc_rem;
  logic [8:0]            burst_beats, beat_cnt, calc_beats;
  logic [7:0]            awlen_q;
  logic [12:0]           dist_bytes, dist_beats;
  logic [CW-1:0]         lim;
  logic                  error_q;
  logic                  aw_hs, w_hs, last_hs, b_hs;
  logic                  unused_ok;

  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign last_hs = w_hs & m_axi_wlast;
  assign b_hs    = m_axi_bvalid & m_axi_bready;

  // Next burst size; in IDLE it is taken straight from the start request so the
  // first AW can be registered on the accepting edge.
  always_comb begin
    if (state == S_IDLE) begin
      calc_addr = start_addr & ~ADDR_WIDTH'(BYTES - 1);
      calc_rem  = total_beats;
    end else begin
      calc_addr = addr;
      calc_rem  = remaining;
    end
    dist_bytes = 13'd4096 - {1'b0, calc_addr[11:0]};
    dist_beats = dist_bytes >> LB;
    lim = CW'(MAX_BURST);
    if (CW'(calc_rem) < lim)   lim = CW'(calc_rem);
    if (CW'(dist_beats) < lim) lim = CW'(dist_beats);
    calc_beats = lim[8:0];
  end

  assign unused_ok = ^{m_axi_bresp[0], lim[CW-1:9]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (total_beats == '0) ? S_DONE : S_ADDR;
      S_ADDR: if (aw_hs) state_nxt = S_DATA;
      S_DATA: if (last_hs) state_nxt = S_RESP;
      S_RESP: if (b_hs) begin
        if (m_axi_bresp[1])          state_nxt = S_DONE;
        else if (remaining == '0)    state_nxt = S_DONE;
        else                         state_nxt = S_ADDR;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state == S_ADDR);
    m_axi_wvalid  = (state == S_DATA) & fifo_not_empty;
    m_axi_wlast   = (state == S_DATA) & (beat_cnt == 9'd1);
    fifo_rd_en    = m_axi_wvalid & m_axi_wready;
    m_axi_bready  = (state == S_RESP);
    done          = (state == S_DONE);
    busy          = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr      <= calc_addr;
        remaining <= total_beats;
        error_q   <= 1'b0;
      end
      if (state_nxt == S_ADDR && state != S_ADDR) begin
        awaddr_q    <= calc_addr;
        awlen_q     <= 8'(calc_beats - 9'd1);
        burst_beats <= calc_beats;
      end
      if (aw_hs) beat_cnt <= burst_beats;
      if (w_hs)  beat_cnt <= beat_cnt - 9'd1;
      // beats <= remaining by construction, so no underflow here
      if (last_hs) begin
        addr      <= addr + (ADDR_WIDTH'(burst_beats) << LB);
        remaining <= remaining - LEN_WIDTH'(burst_beats);
      end
      if (b_hs && m_axi_bresp[1]) error_q <= 1'b1;
    end
  end

  assign error         = error_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(LB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = fifo_dout;
  assign m_axi_wstrb   = '1;

endmodule
